// File: rtl/de_coder_defs.sv
// Shared definitions for the decoder command path: state encodings and word-format defaults.
package de_coder_defs;

    localparam int CMD_W_DEF = 16;
    localparam int OP_W_DEF  = 4;
    localparam logic [3:0] STOP_OP_DEF = 4'hF;

    // 2'b11 is shared: it means CsIssue while com_end is low and CsStop once com_end is set.
    typedef enum logic [1:0] {
        CsIdle    = 2'b00,
        CsRead    = 2'b01,
        CsCapture = 2'b10,
        CsIssue   = 2'b11
    } cs_state_e;

endpackage

// File: rtl/de_coder_consume_con.sv
// Consumer end of the decoder command path. Pops one command at a time from the
// command FIFO, presents it to the execute unit over valid/ready, and raises a
// sticky com_end when the stop opcode is popped.
// Optional feature: define CMD_COUNT_EN to add the saturating cmd_count output.
//
// Handshake: cmd_valid rises with cmd_op/cmd_arg stable and stays high, with the
// data unchanged, until the cycle cmd_ready is high; the command transfers on that
// clock edge. cmd_ready is ignored whenever cmd_valid is low.
module de_coder_consume_con
    import de_coder_defs::*;
#(
    parameter int CMD_W = CMD_W_DEF,
    parameter int OP_W  = OP_W_DEF,
    parameter logic [OP_W-1:0] STOP_OP = OP_W'(STOP_OP_DEF)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [CMD_W-1:0]      fifo_data,
    output logic                  fifo_rd,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [OP_W-1:0]       cmd_op,
    output logic [CMD_W-OP_W-1:0] cmd_arg,
    output logic                  busy,
    output logic                  com_end,
`ifdef CMD_COUNT_EN
    output logic [15:0]           cmd_count,
`endif
    output cs_state_e             dbg_state
);

    cs_state_e               state_q, state_d;
    logic                    com_end_q, com_end_d;
    logic [OP_W-1:0]         op_q, op_d;
    logic [CMD_W-OP_W-1:0]   arg_q, arg_d;
    logic                    accept;

    // Next-state logic; the command word is latched as the FSM leaves CsCapture.
    always_comb begin
        state_d   = state_q;
        com_end_d = com_end_q;
        op_d      = op_q;
        arg_d     = arg_q;
        case (state_q)
            CsIdle: begin
                if (!fifo_empty && !com_end_q) state_d = CsRead;
            end
            CsRead: begin
                state_d = CsCapture;
            end
            CsCapture: begin
                op_d    = fifo_data[CMD_W-1 -: OP_W];
                arg_d   = fifo_data[CMD_W-OP_W-1:0];
                state_d = CsIssue;
                if (fifo_data[CMD_W-1 -: OP_W] == STOP_OP) com_end_d = 1'b1;
            end
            CsIssue: begin
                // With com_end set this is the terminal stop state.
                if (!com_end_q && cmd_ready) state_d = CsIdle;
            end
            default: state_d = CsIdle;
        endcase
    end

    // State and command registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= CsIdle;
            com_end_q <= 1'b0;
            op_q      <= '0;
            arg_q     <= '0;
        end else begin
            state_q   <= state_d;
            com_end_q <= com_end_d;
            op_q      <= op_d;
            arg_q     <= arg_d;
        end
    end

    // Moore outputs decoded from registers only.
    always_comb begin
        fifo_rd   = (state_q == CsRead);
        cmd_valid = (state_q == CsIssue) && !com_end_q;
        busy      = (state_q != CsIdle);
        com_end   = com_end_q;
        cmd_op    = op_q;
        cmd_arg   = arg_q;
        dbg_state = state_q;
        accept    = cmd_valid && cmd_ready;
    end

`ifdef CMD_COUNT_EN
    logic [15:0] cmd_count_q, cmd_count_d;

    // Saturating count of accepted commands; the stop word is never issued so never counted.
    always_comb begin
        cmd_count_d = cmd_count_q;
        if (accept && (cmd_count_q != 16'hFFFF)) cmd_count_d = cmd_count_q + 16'd1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cmd_count_q <= '0;
        else        cmd_count_q <= cmd_count_d;
    end

    assign cmd_count = cmd_count_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_de_coder_consume_con.sv
// Bench for de_coder_consume_con: a queue-based FIFO model, a scoreboard fed in
// push order (every non-stop word before the first stop is expected in order),
// and a negedge monitor that checks each accepted command and handshake rules.
module tb_de_coder_consume_con;
    import de_coder_defs::*;

    logic        clk;
    logic        reset;
    logic        fifo_empty;
    logic [15:0] fifo_data;
    logic        fifo_rd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [11:0] cmd_arg;
    logic        busy;
    logic        com_end;
    cs_state_e   dbg_state;
`ifdef CMD_COUNT_EN
    logic [15:0] cmd_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];
    bit          stop_pushed = 0;
    bit          rand_ready  = 0;
    int          accepted    = 0;
    bit          prev_valid  = 0;
    logic [15:0] prev_cmd    = '0;

    de_coder_consume_con dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .busy       (busy),
        .com_end    (com_end),
`ifdef CMD_COUNT_EN
        .cmd_count  (cmd_count),
`endif
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Driver: push one word into the FIFO and into the reference model.
    task automatic push_word(input logic [15:0] w);
        @(negedge clk);
        fifo_q.push_back(w);
        fifo_empty = 0;
        if (!stop_pushed) begin
            if (w[15:12] == 4'hF) stop_pushed = 1;
            else exp_q.push_back(w);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        fifo_q.delete();
        exp_q.delete();
        stop_pushed = 0;
        fifo_empty  = 1;
        fifo_data   = '0;
        cmd_ready   = 0;
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!cmd_valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, cmd_valid, 1);
    endtask

    task automatic wait_com_end(input string name, input int budget);
        int n = 0;
        while (!com_end && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, com_end, 1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || (stop_pushed && !com_end)) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // FIFO model: pop during the fifo_rd cycle so data is ready for capture.
    always @(negedge clk) begin
        if (reset && fifo_rd) begin
            if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
            else check("fifo_underflow", 1, 0);
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Random back-pressure, changed just after each active edge.
    always @(posedge clk) begin
        #1;
        if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: accepted commands against the scoreboard, plus handshake rules.
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 0;
        end else begin
            if (cmd_valid) check("no_pop_while_valid", fifo_rd, 0);
            if (prev_valid) begin
                check("valid_held", cmd_valid, 1);
                check("data_stable", {cmd_op, cmd_arg}, prev_cmd);
            end
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) check("unexpected_issue", {cmd_op, cmd_arg}, 32'hDEAD_BEEF);
                else check("issued_cmd", {cmd_op, cmd_arg}, exp_q.pop_front());
                accepted++;
                prev_valid = 0;
            end else begin
                prev_valid = cmd_valid;
                prev_cmd   = {cmd_op, cmd_arg};
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        check("watchdog", 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int acc0;
        int n;
        logic [3:0]  op;
        logic [15:0] w;
        reset = 0; fifo_empty = 1; fifo_data = '0; cmd_ready = 0;
        do_reset();
        #1;
        check("rst_busy", busy, 0);
        check("rst_com_end", com_end, 0);
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_op", cmd_op, 0);
        check("rst_cmd_arg", cmd_arg, 0);

        // Single command latency and decode
        cmd_ready = 1;
        push_word(16'h1234);
        @(posedge clk); #1; check("lat_rd_pulse", fifo_rd, 1);
        @(posedge clk); #1; check("lat_rd_once", fifo_rd, 0);
        @(posedge clk); #1;
        check("lat_valid", cmd_valid, 1);
        check("lat_op", cmd_op, 4'h1);
        check("lat_arg", cmd_arg, 12'h234);
        @(posedge clk); #1; check("lat_valid_drop", cmd_valid, 0);
        wait_drain("drain_single", 20);

        // Back-pressure for 10 cycles, then acceptance and re-pop timing
        cmd_ready = 0;
        push_word(16'h5ABC);
        push_word(16'h6DEF);
        wait_valid("bp_valid", 20);
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_valid_held", cmd_valid, 1);
            check("bp_no_pop", fifo_rd, 0);
            check("bp_data", {cmd_op, cmd_arg}, 16'h5ABC);
        end
        cmd_ready = 1;
        @(posedge clk); #1;
        check("bp_accept", cmd_valid, 0);
        check("bp_idle_gap", fifo_rd, 0);
        @(posedge clk); #1;
        check("bp_next_pop", fifo_rd, 1);
        wait_drain("drain_bp", 20);

        // Reset during issue discards the held command
        cmd_ready = 0;
        push_word(16'h7777);
        wait_valid("mid_valid", 20);
        @(negedge clk);
        reset = 0;
        #1;
        check("async_cmd_valid", cmd_valid, 0);
        check("async_busy", busy, 0);
        check("async_fifo_rd", fifo_rd, 0);
        check("async_cmd_op", cmd_op, 0);
        check("async_cmd_arg", cmd_arg, 0);
        check("async_com_end", com_end, 0);
        fifo_q.delete(); exp_q.delete(); stop_pushed = 0; fifo_empty = 1;
        repeat (2) @(negedge clk);
        reset = 1;
        @(posedge clk); #1; check("post_rst_busy", busy, 0);

        // Empty FIFO: nothing happens
        repeat (20) begin
            @(posedge clk); #1;
            check("empty_no_rd", fifo_rd, 0);
            check("empty_not_busy", busy, 0);
        end

        // Stop in the middle of the stream
        cmd_ready = 1;
        acc0 = accepted;
        push_word(16'h2001);
        push_word(16'hF000);
        push_word(16'h3003);
        wait_com_end("stop_seen", 60);
        check("stop_issue_count", accepted - acc0, 1);
        check("stop_left_in_fifo", fifo_q.size(), 1);
        repeat (20) begin
            @(posedge clk); #1;
            check("stop_no_rd", fifo_rd, 0);
            check("stop_no_valid", cmd_valid, 0);
            check("stop_busy", busy, 1);
            check("stop_sticky", com_end, 1);
        end

        // Randomized streams with random back-pressure
        for (int r = 0; r < 6; r++) begin
            do_reset();
            rand_ready = 1;
            n = $urandom_range(3, 8);
            for (int i = 0; i < n; i++) begin
                op = 4'($urandom_range(0, 14));
                if ((r % 2 == 1) && (i == n - 2)) op = 4'hF;
                w = {op, 12'($urandom_range(0, 4095))};
                push_word(w);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_drain("rand_drain", 400);
            check("rand_com_end", com_end, (r % 2 == 1) ? 1 : 0);
            if (r % 2 == 1) check("rand_fifo_left", fifo_q.size(), 1);
            rand_ready = 0;
        end

`ifdef CMD_COUNT_EN
        do_reset();
        cmd_ready = 1;
        push_word(16'h0011);
        push_word(16'h1022);
        push_word(16'h2033);
        push_word(16'hF044);
        wait_com_end("cnt_stop", 80);
        check("cnt_three", cmd_count, 16'd3);
        do_reset();
        cmd_ready = 1;
        @(negedge clk);
        force dut.cmd_count_q = 16'hFFFF;
        #1;
        release dut.cmd_count_q;
        push_word(16'h4055);
        wait_drain("cnt_sat_drain", 20);
        @(posedge clk); #1;
        check("cnt_saturate", cmd_count, 16'hFFFF);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
